pipeline_hazard_ctrl: RTL

Hazard and sequencing controller for the 5-stage ARM pipeline. Each cycle it decides whether the ID/EX control register and its neighbours advance, hold, or take a bubble. It detects RAW data hazards between the ID stage and later stages, flushes on taken branches resolved in EX, and freezes the pipeline while data memory is busy, with a wait timeout that latches a fault. It sits beside the pipeline registers: `id_ex_flush` drives the ID/EX register's bubble input, and the enables gate PC, IF/ID, ID/EX and EX/MEM.

---
 rtl/pipeline_hazard_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage pipeline: RAW stalls, branch flushes, memory freeze with timeout fault.
// Optional feature macro: PIPE_FORWARDING_EN (defined -> only load-use hazards stall).
module pipeline_hazard_ctrl #(
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       id_rn,
    input  logic [3:0]       id_rm,
    input  logic             id_uses_rn,
    input  logic             id_uses_rm,
    input  logic [3:0]       ex_rd,
    input  logic             ex_reg_write,
    input  logic             ex_mem_to_reg,
    input  logic [3:0]       mem_rd,
    input  logic             mem_reg_write,
    input  logic [3:0]       wb_rd,
    input  logic             wb_reg_write,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             pc_enable,
    output logic             if_id_enable,
    output logic             id_ex_enable,
    output logic             ex_mem_enable,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             fault,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] MEM_WAIT = 2'd1;
    localparam logic [1:0] FAULT    = 2'd2;

    logic [1:0]        state, state_nx;
    logic [WAIT_W-1:0] wait_cnt, wait_nx;
    logic              stall_inc, flush_inc;
    logic              ex_hit, mem_hit, wb_hit, load_use, data_hz;

    // R15 is the PC, never a real register dependency.
    function automatic logic src_hit(input logic uses, input logic [3:0] src,
                                     input logic [3:0] rd, input logic wr);
        return uses && wr && (rd == src) && (rd != 4'd15);
    endfunction

    assign ex_hit  = src_hit(id_uses_rn, id_rn, ex_rd, ex_reg_write)
                   | src_hit(id_uses_rm, id_rm, ex_rd, ex_reg_write);
    assign mem_hit = src_hit(id_uses_rn, id_rn, mem_rd, mem_reg_write)
                   | src_hit(id_uses_rm, id_rm, mem_rd, mem_reg_write);
    assign wb_hit  = src_hit(id_uses_rn, id_rn, wb_rd, wb_reg_write)
                   | src_hit(id_uses_rm, id_rm, wb_rd, wb_reg_write);
    assign load_use = ex_hit && ex_mem_to_reg;

`ifdef PIPE_FORWARDING_EN
    assign data_hz = load_use;
    logic unused_hits;
    assign unused_hits = mem_hit | wb_hit;
`else
    assign data_hz = ex_hit | mem_hit | wb_hit;
`endif

    // NOTE: every always_comb output gets a default first so no path leaves a latch.
    always_comb begin
        pc_enable     = 1'b0;
        if_id_enable  = 1'b0;
        id_ex_enable  = 1'b0;
        ex_mem_enable = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        state_nx      = state;
        wait_nx       = wait_cnt;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;
        if (!reset) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (mem_busy) begin
                        state_nx = MEM_WAIT;
                        wait_nx  = WAIT_W'(1);
                    end else if (branch_taken) begin
                        {pc_enable, if_id_enable, id_ex_enable, ex_mem_enable} = 4'b1111;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        flush_inc   = 1'b1;
                    end else if (data_hz) begin
                        id_ex_enable  = 1'b1;
                        ex_mem_enable = 1'b1;
                        id_ex_flush   = 1'b1;
                        stall_inc     = 1'b1;
                    end else begin
                        {pc_enable, if_id_enable, id_ex_enable, ex_mem_enable} = 4'b1111;
                    end
                end
                MEM_WAIT: begin
                    stall_inc = 1'b1;
                    if (!mem_busy) begin
                        state_nx = RUN;
                        wait_nx  = '0;
                    end else if (wait_cnt == WAIT_W'(MAX_WAIT)) begin
                        state_nx = FAULT;
                    end else begin
                        wait_nx = wait_cnt + WAIT_W'(1);
                    end
                end
                FAULT: state_nx = FAULT;
                default: state_nx = RUN;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= RUN;
            wait_cnt    <= '0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_nx;
            if (stall_inc && stall_count != '1)
                stall_count <= stall_count + CNT_W'(1);
            if (flush_inc && flush_count != '1)
                flush_count <= flush_count + CNT_W'(1);
        end
    end

    assign fault = (state == FAULT);

endmodule
